// File: rtl/mips_cpu_muldiv_if.sv
// HI/LO multiply-divide unit port bundle: operation request, MTHI/MTLO writes, results and stall.
interface mips_cpu_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        wrHi;
  logic        wrLo;
  logic [31:0] wrData;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, opA, opB, wrHi, wrLo, wrData,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, opA, opB, wrHi, wrLo, wrData,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO unit: MULT/MULTU shift-add and DIV/DIVU restoring divide on magnitudes.
// Result lands 32 edges after start; busy stalls the pipeline, start/writes are ignored while busy.
module mips_cpu_muldiv (
  input  logic                    clk,
  input  logic                    reset,
  mips_cpu_muldiv_if.slave        bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b_mag;
  logic [31:0] a_raw;
  logic        is_div;
  logic        neg_p;
  logic        neg_r;
  logic        dz;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        sa, sb;
  logic [31:0] a_mag_in, b_mag_in;
  logic [32:0] msum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] acc_nxt;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops work on magnitudes; signs are reapplied when the result is written.
  always_comb begin
    sa       = bus.op[0] & bus.opA[31];
    sb       = bus.op[0] & bus.opB[31];
    a_mag_in = sa ? (32'd0 - bus.opA) : bus.opA;
    b_mag_in = sb ? (32'd0 - bus.opB) : bus.opB;
  end

  always_comb begin
    msum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    rem_sh = {acc[63:32], acc[31]};
    diff   = rem_sh - {1'b0, b_mag};
    if (!is_div)
      acc_nxt = {msum, acc[31:1]};
    else if (!diff[32])
      acc_nxt = {diff[31:0], acc[30:0], 1'b1};
    else
      acc_nxt = {rem_sh[31:0], acc[30:0], 1'b0};
  end

  always_comb begin
    prod   = neg_p ? (64'd0 - acc_nxt) : acc_nxt;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_lo = neg_p ? (32'd0 - acc_nxt[31:0])  : acc_nxt[31:0];
      res_hi = neg_r ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
      if (dz) begin
        res_lo = 32'hFFFF_FFFF;
        res_hi = a_raw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      b_mag  <= 32'd0;
      a_raw  <= 32'd0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          acc    <= {32'd0, a_mag_in};
          b_mag  <= b_mag_in;
          a_raw  <= bus.opA;
          is_div <= bus.op[1];
          neg_p  <= sa ^ sb;
          neg_r  <= sa;
          dz     <= (bus.opB == 32'd0);
          cnt    <= 5'd0;
        end else begin
          if (bus.wrHi) hi_q <= bus.wrData;
          if (bus.wrLo) lo_q <= bus.wrData;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: hand-computed HI/LO results, latency, stall and reset behaviour.
module tb_mips_cpu_muldiv;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation, scrambles operands after the start edge, optionally
  // injects a start plus HI/LO writes mid-flight, then checks timing and results.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject);
    logic [31:0] hi0, lo0;
    int cycles, dones;
    bit stable;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.op = op; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.opA = ~a; bus.opB = b ^ 32'h5; bus.op = ~op;
    cycles = 0; dones = 0; stable = 1'b1;
    while (bus.busy && cycles < 40) begin
      cycles++;
      if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
      if (bus.done) dones++;
      if (inject && cycles == 5) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.opA = 32'd9; bus.opB = 32'd3;
        bus.wrLo = 1'b1; bus.wrHi = 1'b1; bus.wrData = 32'hAA;
      end
      tick();
      bus.start = 1'b0; bus.wrLo = 1'b0; bus.wrHi = 1'b0;
    end
    check({tag, " busy_cycles"}, cycles, 32);
    check({tag, " done_while_busy"}, dones, 0);
    check({tag, " hilo_stable"}, {31'd0, stable}, 32'd1);
    check({tag, " done"}, {31'd0, bus.done}, 32'd1);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    tick();
    check({tag, " done_cleared"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.opA = 32'd0; bus.opB = 32'd0;
    bus.wrHi = 1'b0; bus.wrLo = 1'b0; bus.wrData = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0_neg", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("mult_negneg", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 1'b0);

    bus.wrHi = 1'b1; bus.wrData = 32'h1234;
    tick();
    bus.wrHi = 1'b0;
    check("mthi hi", bus.hi, 32'h1234);
    check("mthi lo_kept", bus.lo, 32'd6);

    bus.wrHi = 1'b1; bus.wrLo = 1'b1; bus.wrData = 32'hCAFE;
    tick();
    bus.wrHi = 1'b0; bus.wrLo = 1'b0;
    check("mthilo hi", bus.hi, 32'hCAFE);
    check("mthilo lo", bus.lo, 32'hCAFE);

    bus.wrHi = 1'b1; bus.wrLo = 1'b1; bus.wrData = 32'h55;
    run_op("start_prio", 2'b00, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0);

    run_op("multu_inject", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

    bus.op = 2'b11; bus.opA = 32'd9; bus.opB = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort no_done", dones, 0);
    check("abort hi_after", bus.hi, 32'd0);
    check("abort lo_after", bus.lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-002 start  input  1  shall request an operation; sampled only when busy=0.
REQ-003 op  input  2  shall select the operation:
- 00 MULTU
- 01 MULT
- 10 DIVU
- 11 DIV
REQ-004 opA  input  32  shall carry the multiplicand or dividend (rs value from the register file read port A).
REQ-005 opB  input  32  shall carry the multiplier or divisor (rt value from the register file read port B).
REQ-006 wrHi  input  1  shall request MTHI: load wrData into HI.
REQ-007 wrLo  input  1  shall request MTLO: load wrData into LO.
REQ-008 wrData  input  32  shall carry the MTHI/MTLO data.
REQ-009 hi  output  32  shall show the current HI register (MFHI source).
REQ-010 lo  output  32  shall show the current LO register (MFLO source).
REQ-011 busy  output  1  shall be high while an operation is in progress, for use as a pipeline stall.
REQ-012 done  output  1  shall pulse for one cycle on the edge where HI/LO receive a result.

Function
REQ-013 States SHALL be IDLE and RUN, with a 5-bit iteration counter.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch op, opA and opB, clear the counter, and enter RUN; busy SHALL read 1 after that edge.
REQ-015 RUN SHALL perform exactly 32 iterations, one per edge (shift-add multiply; restoring divide on magnitudes).
REQ-016 On the 32nd RUN edge, the block SHALL:
- write HI/LO,
- set done=1 for that cycle,
- set busy=0,
- return to IDLE.
REQ-017 Latency: HI/LO SHALL hold the result 32 edges after the start edge, with busy high for exactly 32 cycles.
REQ-018 MULTU SHALL give {HI,LO} = 64-bit unsigned product.
REQ-019 MULT SHALL give {HI,LO} = 64-bit two's-complement product, with the sign applied after magnitude multiplication.
REQ-020 DIVU SHALL give LO = unsigned quotient and HI = unsigned remainder.
REQ-021 DIV SHALL give:
- LO = quotient truncated toward zero;
- HI = remainder, which takes the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no error indication.
REQ-023 Divide by zero (DIV or DIVU, opB=0) SHALL take the normal 32 cycles and give LO=0xFFFFFFFF and HI=opA.
REQ-024 start while busy=1 SHALL be ignored; the operation in flight is unaffected.
REQ-025 wrHi/wrLo while busy=1 SHALL be ignored.
REQ-026 In IDLE, wrHi/wrLo SHALL update HI/LO at the edge, visible next cycle; wrHi and wrLo may both be asserted together.
REQ-027 In IDLE, start together with wrHi/wrLo: start SHALL take priority and the writes SHALL be dropped.
REQ-028 hi/lo SHALL keep their old values throughout RUN; no partial results shall be visible.
REQ-029 Operands SHALL be captured at the start edge; later changes to opA/opB/op SHALL have no effect.

Reset
REQ-030 reset=1 at an edge SHALL:
- set hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0;
- take priority over start, wrHi and wrLo.
REQ-031 reset during RUN SHALL abort the operation with no HI/LO update and no done pulse.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset, then idle 2 cycles -> hi=0, lo=0, busy=0, done=0.
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> busy high 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulsed once.
- MULT opA=-3, opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV opA=-7, opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle.
- During a MULTU 2*3, the following SHALL be ignored:
  - a second start (DIVU 9/3);
  - a wrLo of 0xAA.
  The result SHALL be hi=0, lo=6.
- reset asserted at RUN cycle 10 of DIV 9/3 -> hi=0, lo=0, busy=0, and no done pulse.
